// File: rtl/niios_ram_arb_pkg.sv
// niios_ram_arb_pkg: shared defaults, FSM states and master index type for the RAM arbiter
package niios_ram_arb_pkg;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = 4;
  localparam int DEF_DEPTH  = 5120;
  typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_t;
  typedef logic mst_idx_t;
endpackage

// File: rtl/niios_ram_rr_grant.sv
// niios_ram_rr_grant: 2-way round-robin grant; the last winner yields when both request
module niios_ram_rr_grant
  import niios_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_vld,
  output mst_idx_t   gnt_idx
);
  mst_idx_t rr_last_q, rr_last_d;
  // pick a winner and remember it; rr_last holds when nobody is granted
  always_comb begin
    gnt_vld   = en & |req;
    gnt_idx   = (&req) ? ~rr_last_q : req[1];
    rr_last_d = gnt_vld ? gnt_idx : rr_last_q;
  end
  // rr_last starts at 1 so master 0 wins the first contested cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_last_q <= 1'b1;
    else       rr_last_q <= rr_last_d;
  end
endmodule

// File: rtl/niios_qsys_ram_arbiter.sv
// niios_qsys_ram_arbiter: two Avalon-MM masters onto one RAM port; NIIOS_RAM_ARB_ZEROFILL_EN adds a post-reset zero fill
module niios_qsys_ram_arbiter
  import niios_ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DEF_BE_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  output logic              ram_reset_req,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              busy
);
  state_t            state_q, state_d;
  logic              gnt_vld, wr, in_rng, init, fill_done;
  mst_idx_t          sel;
  logic [ADDR_W-1:0] addr, fill_addr;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        vld_q, vld_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];

  niios_ram_rr_grant u_grant (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q == ST_RUN),
    .req     ({m1_read | m1_write, m0_read | m0_write}),
    .gnt_vld (gnt_vld),
    .gnt_idx (sel)
  );

`ifdef NIIOS_RAM_ARB_ZEROFILL_EN
  localparam state_t ST_AFTER_RST = ST_INIT;
  logic [ADDR_W-1:0] fill_q, fill_d;
  assign fill_d    = (state_q == ST_INIT) ? fill_q + ADDR_W'(1) : '0;
  assign fill_addr = fill_q;
  assign fill_done = fill_q == ADDR_W'(DEPTH - 1);
  assign init      = state_q == ST_INIT;
  // fill pointer walks one word per INIT cycle and rewinds whenever INIT is left or reset hits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fill_q <= '0;
    else       fill_q <= fill_d;
  end
`else
  localparam state_t ST_AFTER_RST = ST_RUN;
  assign fill_addr = '0;
  assign fill_done = 1'b1;
  assign init      = 1'b0;
`endif

  // sequencing: RST for one cycle, optional INIT fill, then RUN forever
  always_comb begin
    state_d = (state_q == ST_RST) ? ST_AFTER_RST :
              (state_q == ST_INIT && fill_done) ? ST_RUN : state_q;
  end

  // route the granted master (or the fill engine) to the RAM and queue the read return
  always_comb begin
    addr           = sel ? m1_address : m0_address;
    be             = sel ? m1_byteenable : m0_byteenable;
    wdata          = sel ? m1_writedata : m0_writedata;
    wr             = sel ? m1_write : m0_write;
    in_rng         = gnt_vld & (addr < ADDR_W'(DEPTH));
    ram_address    = init ? fill_addr : addr;
    ram_byteenable = init ? '1 : be;
    ram_writedata  = init ? '0 : wdata;
    ram_chipselect = init | in_rng;
    ram_write      = init | (in_rng & wr);
    m0_waitrequest = ~(gnt_vld & ~sel);
    m1_waitrequest = ~(gnt_vld & sel);
    vld_d          = {gnt_vld & ~wr & sel, gnt_vld & ~wr & ~sel};
    rdata_d[0]     = vld_d[0] ? (in_rng ? ram_readdata : '0) : rdata_q[0];
    rdata_d[1]     = vld_d[1] ? (in_rng ? ram_readdata : '0) : rdata_q[1];
  end

  // state and read-return registers; reset drops any read still in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RST;
      vld_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  assign m0_readdatavalid = vld_q[0];
  assign m1_readdatavalid = vld_q[1];
  assign m0_readdata      = rdata_q[0];
  assign m1_readdata      = rdata_q[1];
  assign ram_clken        = 1'b1;
  assign ram_reset_req    = 1'b0;
  assign busy             = init;
endmodule

// File: tb/tb_niios_qsys_ram_arbiter.sv
// tb_niios_qsys_ram_arbiter: random and directed traffic against a behavioural arbiter/RAM model
module tb_niios_qsys_ram_arbiter;
  localparam int DEPTH = 5120;
  logic clk = 1'b0, reset = 1'b1, preload = 1'b0;
  logic [12:0] a [2];
  logic [3:0]  be [2];
  logic        rd [2], wr [2], wt [2], rdv [2];
  logic [31:0] wd [2], rdd [2];
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken, ram_reset_req, busy;
  logic [31:0] ram_writedata, ram_readdata;
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ed [2];
  bit          ev [2];
  int          rr_last = 1, last_g = -1, total = 0, bad = 0;

  always #5 clk = ~clk;

  niios_qsys_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(a[0]), .m0_byteenable(be[0]), .m0_read(rd[0]), .m0_write(wr[0]),
    .m0_writedata(wd[0]), .m0_waitrequest(wt[0]), .m0_readdata(rdd[0]), .m0_readdatavalid(rdv[0]),
    .m1_address(a[1]), .m1_byteenable(be[1]), .m1_read(rd[1]), .m1_write(wr[1]),
    .m1_writedata(wd[1]), .m1_waitrequest(wt[1]), .m1_readdata(rdd[1]), .m1_readdatavalid(rdv[1]),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_reset_req(ram_reset_req), .ram_readdata(ram_readdata), .busy(busy)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // RAM with asynchronous read; out-of-range addresses return junk the arbiter must hide
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    else if (ram_chipselect && ram_write)
      for (int b = 0; b < 4; b++) if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
  end
  assign ram_readdata = (ram_address < 13'(DEPTH)) ? mem[ram_address] : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; a[i] = '0; be[i] = '0; wd[i] = '0;
    end
  endtask

  // one RUN cycle: check against the model at negedge, then advance the model and the clock
  task automatic tick();
    int g;
    bit q0, q1, inr;
    @(negedge clk);
    q0 = rd[0] | wr[0];
    q1 = rd[1] | wr[1];
    g = (q0 && q1) ? 1 - rr_last : q0 ? 0 : q1 ? 1 : -1;
    inr = 1'b0;
    if (g >= 0) inr = a[g] < 13'(DEPTH);
    for (int i = 0; i < 2; i++) check("waitrequest", 32'(wt[i]), (g == i) ? 0 : 1);
    check("chipselect", 32'(ram_chipselect), 32'(inr));
    if (inr) begin
      check("ram_address", 32'(ram_address), 32'(a[g]));
      check("ram_write", 32'(ram_write), 32'(wr[g]));
      if (wr[g]) begin
        check("ram_be", 32'(ram_byteenable), 32'(be[g]));
        check("ram_wdata", ram_writedata, wd[g]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      check("rdvalid", 32'(rdv[i]), 32'(ev[i]));
      if (ev[i]) check("rdata", rdd[i], ed[i]);
    end
    ev[0] = 1'b0;
    ev[1] = 1'b0;
    if (g >= 0) begin
      if (wr[g]) begin
        if (inr) for (int b = 0; b < 4; b++) if (be[g][b]) ref_mem[a[g]][b*8 +: 8] = wd[g][b*8 +: 8];
      end else begin
        ev[g] = 1'b1;
        ed[g] = inr ? ref_mem[a[g]] : 32'h0;
      end
      rr_last = g;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int n, seq_bad;
    reset = 1'b1;
    idle();
    ev[0] = 1'b0;
    ev[1] = 1'b0;
    rr_last = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    seq_bad = 0;
`ifdef NIIOS_RAM_ARB_ZEROFILL_EN
    rd[0] = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (busy) begin
        if (!wt[0] || !wt[1] || ram_address != 13'(n) || !ram_chipselect || !ram_write ||
            ram_byteenable != 4'hF || ram_writedata != 32'h0) seq_bad++;
        n++;
      end else if (n > 0) break;
    end
    rd[0] = 1'b0;
    check("fill_len", n, DEPTH);
    check("fill_seq", seq_bad, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    @(posedge clk);
    #1;
`else
    @(posedge clk);
    #1;
    check("busy_off", 32'(busy), 0);
    check("fill_len", n + seq_bad, 0);
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    preload = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    check("rst_wait0", 32'(wt[0]), 1);
    check("rst_wait1", 32'(wt[1]), 1);
    check("rst_rdv0", 32'(rdv[0]), 0);
    check("rst_rdata1", rdd[1], 0);
    check("rst_cs", 32'(ram_chipselect), 0);
    check("clken", 32'(ram_clken), 1);
    check("reset_req", 32'(ram_reset_req), 0);
    do_reset();
`ifdef NIIOS_RAM_ARB_ZEROFILL_EN
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 300 && !hit; c++) begin
        @(negedge clk);
        hit = busy && ram_address == 13'd100;
      end
      check("fill_hit100", 32'(hit), 1);
      reset = 1'b1;
      do_reset();
      idle();
      rd[0] = 1'b1;
      a[0] = 13'h13FF;
      tick();
      idle();
      check("fill_rd_13ff", rdd[0], 0);
      tick();
    end
`endif
    for (int k = 0; k < 8; k++) begin
      rd[0] = 1'b1; a[0] = 13'(k);
      rd[1] = 1'b1; a[1] = 13'(100 + k);
      tick();
      check("rr_alternate", last_g, k % 2);
    end
    idle();
    tick();
    wr[0] = 1'b1; a[0] = 13'h010; wd[0] = 32'hDEADBEEF; be[0] = 4'hF;
    tick();
    idle();
    rd[0] = 1'b1; a[0] = 13'h010;
    tick();
    idle();
    check("t1_rdv", 32'(rdv[0]), 1);
    check("t1_data", rdd[0], 32'hDEADBEEF);
    wr[1] = 1'b1; a[1] = 13'h020; wd[1] = 32'h11223344; be[1] = 4'hF;
    tick();
    be[1] = 4'b0010; wd[1] = 32'h0000AB00;
    tick();
    idle();
    rd[1] = 1'b1; a[1] = 13'h020;
    tick();
    idle();
    check("t3_data", rdd[1], 32'h1122AB44);
    rd[0] = 1'b1; a[0] = 13'd5120;
    tick();
    idle();
    check("oor_rdv", 32'(rdv[0]), 1);
    check("oor_data", rdd[0], 0);
    wr[0] = 1'b1; a[0] = 13'd5200; wd[0] = 32'hCAFEF00D; be[0] = 4'hF;
    tick();
    idle();
    rd[0] = 1'b1; a[0] = 13'd5119;
    tick();
    idle();
    check("last_word", rdd[0], ref_mem[DEPTH-1]);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        int r;
        r = int'($urandom_range(0, 3));
        rd[i] = (r == 1) || (r == 3);
        wr[i] = r >= 2;
        a[i]  = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(5110, 5130)) : 13'($urandom_range(0, 31));
        be[i] = 4'($urandom);
        wd[i] = $urandom;
      end
      tick();
    end
    idle();
    tick();
    rd[0] = 1'b1; a[0] = 13'd3;
    tick();
    rd[0] = 1'b1; a[0] = 13'd4;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_wait0", 32'(wt[0]), 1);
    check("mid_wait1", 32'(wt[1]), 1);
    check("mid_rdv0", 32'(rdv[0]), 0);
    check("mid_rdata0", rdd[0], 0);
    check("mid_cs", 32'(ram_chipselect), 0);
    idle();
    @(posedge clk);
    #1;
    check("mid_rdv_after", 32'(rdv[0]), 0);
    do_reset();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
